servo_frame_scheduler: RTL
==========================

# servo_frame_scheduler

Time-multiplexed pulse scheduler for the servo tester. It drives up to N_CH servo outputs from one shared microsecond timebase and one frame counter. Each channel gets a fixed slot in a repeating frame, with a pulse width derived from an 8-bit position. Positions are double-buffered so host writes never disturb a frame in progress. The block sits between the pin-level input decoding (position and channel select from the dedicated inputs) and the servo output pins.

## Interface

Parameters:
- TICK_DIV, 10: clocks per 1 µs tick (10 MHz clk).
- N_CH, 4: number of servo channels.
- FRAME_US, 20000: frame period in ticks.
- SLOT_US, 2500: slot spacing in ticks.
- MIN_US, 1000: pulse width at position 0.
- STEP_US, 4: width increment per position LSB.

Ports:
- clk  in  1  single clock, the only clock.
- rst  in  1  synchronous reset, active-high.
- en  in  1  run enable; low holds the block idle.
- wr_en  in  1  position write strobe.
- wr_ch  in  clog2(N_CH)  channel to write.
- wr_pos  in  8  position value.
- ch_mask  in  N_CH  per-channel output enable.
- servo_out  out  N_CH  servo pulse outputs (registered).
- frame_sync  out  1  one-clock strobe at each frame start.
- active_ch  out  clog2(N_CH)  channel whose slot is current.
- pulse_active  out  1  OR of servo_out.

## Operation

- **Reset values:** servo_out=0, frame_sync=0, active_ch=0, pulse_active=0. Prescaler=0, frame_cnt=0, state IDLE. All shadow and active positions = 8'd128.
- **Tick:** prescaler counts 0..TICK_DIV-1 while en=1 and is held at 0 while en=0. tick=1 in the cycle where prescaler==TICK_DIV-1 and en=1.
- **Frame counter:** frame_cnt (clog2(FRAME_US) bits) increments on each tick and wraps FRAME_US-1 -> 0.
- **Frame start** is a tick with frame_cnt==0. On that tick:
  - copy shadow -> active positions for all channels;
  - snapshot ch_mask;
  - assert frame_sync for one clock.
- **Pulse width:** width_k = MIN_US + STEP_US*pos_k, unsigned, 12 bits, no saturation. Defaults give 1000..2020 ticks.
- **States:** IDLE, WAIT_SLOT, PULSE, TAIL.
  - IDLE -> WAIT_SLOT: on the first frame-start tick while en=1.
  - WAIT_SLOT(k) -> PULSE(k): on the tick with frame_cnt == k*SLOT_US. servo_out[k] is set only if mask_snap[k]=1; a masked slot still consumes its time with the output held low. active_ch=k from this tick.
  - PULSE(k) -> WAIT_SLOT(k+1): on the tick with frame_cnt == k*SLOT_US + width_k. servo_out[k] is cleared on that tick. If k==N_CH-1, go to TAIL instead.
  - TAIL -> WAIT_SLOT(0): on the next frame-start tick, which also performs the latch.
- At most one servo_out bit is high at any time.
- **Writes:** wr_en=1 sets shadow[wr_ch]=wr_pos in the next clock, in any state, including while en=0. wr_ch >= N_CH is ignored.
- **Write in the same cycle as a frame-start tick:** the frame latch uses the pre-write shadow, so the new value applies one frame later.
- **en falling:** at the next edge, state=IDLE, servo_out=0, pulse_active=0, active_ch=0, prescaler=0, frame_cnt=0. Shadow and active positions are retained. A truncated pulse is not completed.
- **en rising:** a fresh frame starts at the first tick.
- **rst** overrides en and wr_en in all states.
- **Parameter legality (elaboration check):**
  - SLOT_US > MIN_US + 255*STEP_US;
  - (N_CH-1)*SLOT_US + MIN_US + 255*STEP_US < FRAME_US.

## Timing

- The first tick after en is sampled high falls in cycle TICK_DIV-1 (cycle 0 = first cycle with en=1). servo_out[0] rises at the following edge, TICK_DIV clocks after en.
- Pulse high time = width_k*TICK_DIV clocks exactly.
- Rising edges of consecutive channels are SLOT_US*TICK_DIV clocks apart.
- Frame period = FRAME_US*TICK_DIV clocks.
- frame_sync rises on the same edge as servo_out[0] and is high for one clock.
- All outputs change only on tick-qualified edges, except on en falling and on rst.
- Write-to-effect latency: applied at the next frame start strictly after the write cycle.

## Test plan

- **Defaults from reset:** rst, then en=1, no writes, ch_mask=4'hF.
  - servo_out[0] rises 10 clocks after en and stays high 15120 clocks (1512 µs).
  - servo_out[1..3] rise 25000 clocks apart.
  - frame_sync repeats every 200000 clocks.
- **Mid-frame writes:** write ch2=0 and ch3=255 during slot 0.
  - Current frame: ch2 and ch3 stay at 15120 clocks.
  - Next frame: ch2=10000 clocks, ch3=20200 clocks.
- **Masking:** ch_mask=4'b0101.
  - Only servo_out[0] and servo_out[2] pulse; bits 1 and 3 stay 0.
  - pulse_active is low during slots 1 and 3; active_ch still steps 0,1,2,3.
- **Write on frame-start tick:** write ch0=0 in the same cycle as a frame-start tick.
  - That frame: ch0 stays 15120 clocks.
  - Following frame: ch0 is 10000 clocks.
- **en drop mid-pulse:** en=0 during the ch1 pulse.
  - servo_out=0 and active_ch=0 at the next edge; no frame_sync while en=0.
  - en=1 again: ch0 rises 10 clocks later with the last latched positions.
- **rst mid-pulse:** assert rst during a ch2 pulse.
  - All outputs are 0 at the next edge.
  - After release and en=1, every channel returns to 15120 clocks (position 128).

Source files
------------

// File: rtl/servo_frame_scheduler.sv
// Time-multiplexed servo pulse scheduler: one microsecond timebase, one frame counter,
// a fixed slot per channel and double-buffered 8-bit positions latched at frame start.
module servo_frame_scheduler #(
  parameter int TICK_DIV = 10,
  parameter int N_CH     = 4,
  parameter int FRAME_US = 20000,
  parameter int SLOT_US  = 2500,
  parameter int MIN_US   = 1000,
  parameter int STEP_US  = 4,
  localparam int CH_W    = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            en_i,
  input  logic            wr_en_i,
  input  logic [CH_W-1:0] wr_ch_i,
  input  logic [7:0]      wr_pos_i,
  input  logic [N_CH-1:0] ch_mask_i,
  output logic [N_CH-1:0] servo_out_o,
  output logic            frame_sync_o,
  output logic [CH_W-1:0] active_ch_o,
  output logic            pulse_active_o
);

  localparam int PS_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int FC_W = $clog2(FRAME_US);
  localparam logic [PS_W-1:0] PS_LAST   = PS_W'(TICK_DIV - 1);
  localparam logic [FC_W-1:0] FC_LAST   = FC_W'(FRAME_US - 1);
  localparam logic [FC_W-1:0] SLOT_STEP = FC_W'(SLOT_US);
  localparam logic [CH_W-1:0] LAST_CH   = CH_W'(N_CH - 1);
  localparam logic [7:0]      POS_RESET = 8'd128;

  if (SLOT_US <= MIN_US + 255 * STEP_US) begin : g_bad_slot
    $error("SLOT_US must exceed the widest pulse MIN_US + 255*STEP_US");
  end
  if ((N_CH - 1) * SLOT_US + MIN_US + 255 * STEP_US >= FRAME_US) begin : g_bad_frame
    $error("the last slot's widest pulse must end before the frame wraps");
  end

  typedef enum logic [1:0] {IDLE, WAIT_SLOT, PULSE, TAIL} state_e;

  state_e          state_q, state_d;
  logic [PS_W-1:0] prescaler_q, prescaler_d;
  logic [FC_W-1:0] frame_cnt_q, frame_cnt_d;
  logic [CH_W-1:0] slot_q, slot_d;
  logic [FC_W-1:0] slot_base_q, slot_base_d;
  logic [CH_W-1:0] active_ch_q, active_ch_d;
  logic [N_CH-1:0] servo_q, servo_d;
  logic            frame_sync_q, frame_sync_d;
  logic [N_CH-1:0] mask_q, mask_d;
  logic [7:0]      shadow_q [N_CH];
  logic [7:0]      shadow_d [N_CH];
  logic [7:0]      active_q [N_CH];
  logic [7:0]      active_d [N_CH];

  logic            tick;
  logic            frame_start;
  logic [11:0]     cur_width;
  logic [FC_W-1:0] pulse_end;

  assign tick        = en_i && (prescaler_q == PS_LAST);
  assign frame_start = tick && (frame_cnt_q == '0);
  assign cur_width   = 12'(MIN_US) + 12'(STEP_US) * {4'd0, active_q[slot_q]};
  assign pulse_end   = slot_base_q + FC_W'(cur_width);

  always_comb begin
    // NOTE: every _d takes its hold value first, so no branch can leave one unassigned (no latches).
    state_d      = state_q;
    prescaler_d  = prescaler_q;
    frame_cnt_d  = frame_cnt_q;
    slot_d       = slot_q;
    slot_base_d  = slot_base_q;
    active_ch_d  = active_ch_q;
    servo_d      = servo_q;
    frame_sync_d = 1'b0;
    mask_d       = mask_q;
    shadow_d     = shadow_q;
    active_d     = active_q;

    if (wr_en_i && (int'(wr_ch_i) < N_CH)) begin
      shadow_d[wr_ch_i] = wr_pos_i;
    end

    if (!en_i) begin
      state_d     = IDLE;
      prescaler_d = '0;
      frame_cnt_d = '0;
      slot_d      = '0;
      slot_base_d = '0;
      active_ch_d = '0;
      servo_d     = '0;
    end else begin
      prescaler_d = (prescaler_q == PS_LAST) ? '0 : prescaler_q + PS_W'(1);
      if (tick) begin
        frame_cnt_d = (frame_cnt_q == FC_LAST) ? '0 : frame_cnt_q + FC_W'(1);
        // The latch reads shadow_q, so a write landing on this same edge waits one frame.
        if (frame_start) begin
          active_d     = shadow_q;
          mask_d       = ch_mask_i;
          frame_sync_d = 1'b1;
        end
        unique case (state_q)
          // Slot 0 opens at frame_cnt 0, so the frame-start tick also starts its pulse.
          IDLE, TAIL: begin
            if (frame_start) begin
              state_d     = PULSE;
              slot_d      = '0;
              slot_base_d = '0;
              active_ch_d = '0;
              servo_d     = ch_mask_i[0] ? N_CH'(1) : '0;
            end
          end
          WAIT_SLOT: begin
            if (frame_cnt_q == slot_base_q) begin
              state_d     = PULSE;
              active_ch_d = slot_q;
              servo_d     = mask_q[slot_q] ? (N_CH'(1) << slot_q) : '0;
            end
          end
          PULSE: begin
            if (frame_cnt_q == pulse_end) begin
              servo_d = '0;
              if (slot_q == LAST_CH) begin
                state_d = TAIL;
              end else begin
                state_d     = WAIT_SLOT;
                slot_d      = slot_q + CH_W'(1);
                slot_base_d = slot_base_q + SLOT_STEP;
              end
            end
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk_i) begin
    // NOTE: state registers take non-blocking assignments only; all decisions live in always_comb.
    if (rst_i) begin
      state_q      <= IDLE;
      prescaler_q  <= '0;
      frame_cnt_q  <= '0;
      slot_q       <= '0;
      slot_base_q  <= '0;
      active_ch_q  <= '0;
      servo_q      <= '0;
      frame_sync_q <= 1'b0;
      mask_q       <= '0;
      // NOTE: the position banks are small flop arrays with a defined mid-travel reset, not RAM.
      shadow_q     <= '{default: POS_RESET};
      active_q     <= '{default: POS_RESET};
    end else begin
      state_q      <= state_d;
      prescaler_q  <= prescaler_d;
      frame_cnt_q  <= frame_cnt_d;
      slot_q       <= slot_d;
      slot_base_q  <= slot_base_d;
      active_ch_q  <= active_ch_d;
      servo_q      <= servo_d;
      frame_sync_q <= frame_sync_d;
      mask_q       <= mask_d;
      shadow_q     <= shadow_d;
      active_q     <= active_d;
    end
  end

  assign servo_out_o    = servo_q;
  assign frame_sync_o   = frame_sync_q;
  assign active_ch_o    = active_ch_q;
  assign pulse_active_o = |servo_q;

endmodule
